// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: FSM states, nop encoding and
// instruction field positions.
package mips_pkg;

  localparam int          PC_WIDTH_DEF = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0;
  localparam int          OPC_MSB      = 31;
  localparam int          OPC_LSB      = 26;
  localparam int          OPC_W        = OPC_MSB - OPC_LSB + 1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    FULL  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory handshake: one request held until a single-cycle ack.
interface instruction_fetch_if #(
  parameter int PC_WIDTH = mips_pkg::PC_WIDTH_DEF
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [31:0]         imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a one-entry skid buffer in front of it.
// Flush wins over every other control; load and pop are mutually exclusive.
module if_id_skid
  import mips_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                skid_wr_i,
  input  logic                skid_pop_i,
  input  logic                clear_i,
  input  logic                flush_i,
  input  logic [31:0]         instr_i,
  input  logic [PC_WIDTH-1:0] pc4_i,
  output logic                valid_o,
  output logic [31:0]         instr_o,
  output logic [PC_WIDTH-1:0] pc4_o
);

  logic                valid_q, valid_d;
  logic [31:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc4_q, pc4_d;
  logic                sk_valid_q, sk_valid_d;
  logic [31:0]         sk_instr_q, sk_instr_d;
  logic [PC_WIDTH-1:0] sk_pc4_q, sk_pc4_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    sk_valid_d = sk_valid_q;
    sk_instr_d = sk_instr_q;
    sk_pc4_d   = sk_pc4_q;
    if (flush_i) begin
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      sk_valid_d = 1'b0;
      sk_instr_d = NOP_INSTR;
    end else begin
      if (load_i) begin
        valid_d = 1'b1;
        instr_d = instr_i;
        pc4_d   = pc4_i;
      end else if (skid_pop_i) begin
        valid_d    = sk_valid_q;
        instr_d    = sk_instr_q;
        pc4_d      = sk_pc4_q;
        sk_valid_d = 1'b0;
      end else if (clear_i) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
      if (skid_wr_i) begin
        sk_valid_d = 1'b1;
        sk_instr_d = instr_i;
        sk_pc4_d   = pc4_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc4_q      <= '0;
      sk_valid_q <= 1'b0;
      sk_instr_q <= NOP_INSTR;
      sk_pc4_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      sk_valid_q <= sk_valid_d;
      sk_instr_q <= sk_instr_d;
      sk_pc4_q   <= sk_pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC and fetch FSM, drives the instruction-memory
// handshake and steers responses into the IF/ID register or skid buffer.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int                  PC_WIDTH = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instruction_fetch_if.master       imem,
  input  logic                      stall,
  input  logic                      branch_taken,
  input  logic [PC_WIDTH-1:0]       branch_target,
  output logic                      if_id_valid,
  output logic [31:0]               if_id_instr,
  output logic [PC_WIDTH-1:0]       if_id_pc4,
  output logic [OPC_W-1:0]          if_id_opcode
);

  fetch_state_e        state_q, state_d;
  logic                active_q;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic [PC_WIDTH-1:0] pc_plus4, target_al, addr;
  logic                req, ack;
  logic                load, skid_wr, skid_pop, clear, flush;
  logic                unused_tgt_bits;

  // active_q keeps the request low for the first cycle out of reset.
  assign req       = active_q && (state_q != FULL);
  assign ack       = req && imem.imem_ack;
  assign addr      = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign pc_plus4  = pc_q + PC_WIDTH'(4);
  assign target_al = {branch_target[PC_WIDTH-1:2], 2'b00};

  assign unused_tgt_bits = ^branch_target[1:0];
  assign imem.imem_req   = req;
  assign imem.imem_addr  = addr;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    load         = 1'b0;
    skid_wr      = 1'b0;
    skid_pop     = 1'b0;
    clear        = 1'b0;
    flush        = 1'b0;
    if (branch_taken) begin
      // Redirect overrides stall and ack; a still-open request must be drained.
      flush = 1'b1;
      pc_d  = target_al;
      if (req && !imem.imem_ack) begin
        state_d      = DRAIN;
        drain_addr_d = addr;
      end else begin
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ack) begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_wr = 1'b1;
              state_d = FULL;
            end else begin
              load = 1'b1;
            end
          end else if (!stall) begin
            clear = 1'b1;
          end
        end
        DRAIN: if (ack) state_d = FETCH;
        FULL: begin
          if (!stall) begin
            skid_pop = 1'b1;
            state_d  = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      active_q     <= 1'b0;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= 1'b1;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  if_id_skid #(.PC_WIDTH(PC_WIDTH)) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .skid_wr_i  (skid_wr),
    .skid_pop_i (skid_pop),
    .clear_i    (clear),
    .flush_i    (flush),
    .instr_i    (imem.imem_rdata),
    .pc4_i      (pc_plus4),
    .valid_o    (if_id_valid),
    .instr_o    (if_id_instr),
    .pc4_o      (if_id_pc4)
  );

  assign if_id_opcode = if_id_instr[OPC_MSB:OPC_LSB];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a transaction-level model of the fetch stage.
module tb_instruction_fetch;
  import mips_pkg::*;

  localparam int          PW     = 32;
  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n, stall, branch_taken;
  logic [31:0] branch_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc4;
  logic [5:0]  if_id_opcode;

  int n_chk = 0;
  int n_err = 0;

  instruction_fetch_if #(.PC_WIDTH(PW)) imem ();

  instruction_fetch #(.PC_WIDTH(PW), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_opcode  (if_id_opcode)
  );

  always #5 clk = ~clk;

  // Reference model: fetch pointer, a pending-discard flag, a buffer queue and
  // the decode-facing slot.
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } ent_t;
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_discard;
  logic [31:0] m_stale_addr;
  ent_t        m_buf[$];
  bit          m_v;
  logic [31:0] m_instr, m_pc4;

  function automatic bit m_req();
    return m_started && (m_buf.size() == 0);
  endfunction

  function automatic logic [31:0] m_addr();
    return m_discard ? m_stale_addr : m_pc;
  endfunction

  task automatic model_step();
    bit   req_now, acked;
    ent_t e;
    req_now = m_req();
    acked   = req_now && imem.imem_ack;
    if (!rst_n) begin
      m_pc = RST_PC; m_started = 0; m_discard = 0; m_buf.delete();
      m_v = 0; m_instr = 32'h0; m_pc4 = 32'h0;
    end else begin
      if (branch_taken) begin
        if (req_now && !imem.imem_ack && !m_discard) m_stale_addr = m_pc;
        m_discard = req_now && !imem.imem_ack;
        m_pc      = branch_target & 32'hFFFF_FFFC;
        m_buf.delete();
        m_v = 0; m_instr = 32'h0;
      end else if (m_discard) begin
        if (acked) m_discard = 0;
      end else if (m_buf.size() != 0) begin
        if (!stall) begin
          e = m_buf.pop_front();
          m_v = 1; m_instr = e.instr; m_pc4 = e.pc4;
        end
      end else if (acked) begin
        e.instr = imem.imem_rdata;
        e.pc4   = m_pc + 32'd4;
        if (stall) m_buf.push_back(e);
        else begin m_v = 1; m_instr = e.instr; m_pc4 = e.pc4; end
        m_pc = m_pc + 32'd4;
      end else if (!stall) begin
        m_v = 0; m_instr = 32'h0;
      end
      m_started = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ins;
    ins = m_instr;
    chk("req", 32'(imem.imem_req), 32'(m_req()));
    if (m_req()) chk("addr", imem.imem_addr, m_addr());
    chk("valid", 32'(if_id_valid), 32'(m_v));
    chk("instr", if_id_instr, ins);
    if (m_v) chk("pc4", if_id_pc4, m_pc4);
    chk("opcode", 32'(if_id_opcode), 32'(ins[31:26]));
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] rd);
    stall = st; branch_taken = br; branch_target = tgt;
    imem.imem_ack = ack; imem.imem_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    m_pc = RST_PC; m_started = 0; m_discard = 0; m_stale_addr = 0;
    m_v = 0; m_instr = 0; m_pc4 = 0;
    tick(); tick();
    chk("rst_req", 32'(imem.imem_req), 32'd0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", if_id_instr, 32'd0);
    chk("rst_pc4", if_id_pc4, 32'd0);
    chk("rst_opcode", 32'(if_id_opcode), 32'd0);

    // Sequential fetch with memory returning the address as data.
    rst_n = 1'b1;
    tick();
    chk("first_addr", imem.imem_addr, 32'h100);
    chk("first_req", 32'(imem.imem_req), 32'd1);
    drive(0, 0, 0, 1, 32'h100); tick();
    chk("pc4_after_ack", if_id_pc4, 32'h104);
    chk("addr2", imem.imem_addr, 32'h104);
    drive(0, 0, 0, 1, 32'h104); tick();
    chk("addr3", imem.imem_addr, 32'h108);
    drive(0, 0, 0, 0, 0); tick();

    // Redirect while 0x108 is outstanding; ack arrives two cycles later.
    drive(0, 1, 32'h203, 0, 0); tick();
    chk("br_valid", 32'(if_id_valid), 32'd0);
    chk("drain_addr", imem.imem_addr, 32'h108);
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 32'hDEAD_BEEF); tick();
    chk("br_target_addr", imem.imem_addr, 32'h200);
    chk("drain_discard", 32'(if_id_valid), 32'd0);
    drive(0, 0, 0, 1, 32'h200); tick();
    chk("br_instr", if_id_instr, 32'h200);

    // Three stall cycles with an ack on the first one.
    drive(1, 0, 0, 1, 32'h1111_2222); tick();
    chk("stall_hold", if_id_instr, 32'h200);
    chk("full_req", 32'(imem.imem_req), 32'd0);
    drive(1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0); tick();
    chk("stall_hold3", if_id_instr, 32'h200);
    drive(0, 0, 0, 0, 0); tick();
    chk("skid_instr", if_id_instr, 32'h1111_2222);
    chk("skid_pc4", if_id_pc4, 32'h208);
    chk("skid_addr", imem.imem_addr, 32'h208);

    // Redirect and ack together under stall: data dropped, buffer stays empty.
    drive(1, 1, 32'h3000, 1, 32'h5555); tick();
    chk("brack_valid", 32'(if_id_valid), 32'd0);
    chk("brack_addr", imem.imem_addr, 32'h3000);
    drive(0, 0, 0, 0, 0); tick();
    chk("brack_empty", 32'(if_id_valid), 32'd0);

    // PC wrap; low target bits must be ignored.
    drive(0, 1, 32'hFFFF_FFFF, 1, 32'h0); tick();
    chk("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 1, 32'hABCD_0000); tick();
    chk("wrap_next", imem.imem_addr, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h0);

    // Reset while draining.
    drive(0, 0, 0, 0, 0); tick();
    drive(0, 1, 32'h40, 0, 0); tick();
    chk("pre_rst_drain", imem.imem_addr, 32'h0);
    rst_n = 1'b0; drive(0, 0, 0, 0, 0); tick();
    chk("drain_rst_req", 32'(imem.imem_req), 32'd0);
    chk("drain_rst_valid", 32'(if_id_valid), 32'd0);
    rst_n = 1'b1; tick();
    chk("resume_addr", imem.imem_addr, 32'h100);
    drive(0, 0, 0, 1, 32'h0000_0077); tick();
    chk("resume_pc4", if_id_pc4, 32'h104);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic a;
      a = m_req() && ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0, $urandom(), a, $urandom());
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
